multichannel_cs_accumulator: RTL and testbench
==============================================

// Module: multichannel_cs_accumulator
// PURPOSE
//  Multi-channel carry-save accumulator: NUM_CHANNELS independent redundant (sum,carry) accumulators
//  sharing one input port and one chunked carry-propagate resolver. Accepts one operand per cycle at
//  full rate with no carry propagation, and resolves a selected channel on request. Sits between
//  operand producers (e.g. multiplier partial-product streams) and result consumers in the arithmetic datapath.
// PARAMETERS
//  INPUT_LENGTH   16  operand width
//  OUTPUT_LENGTH  32  accumulator/result width; must be >= INPUT_LENGTH
//  NUM_CHANNELS   4   independent accumulators (>=1); CH_W = max(1,clog2(NUM_CHANNELS)) is a localparam
//  ADDER_WIDTH    8   resolver bits per cycle; must divide OUTPUT_LENGTH
//  SIGNED         0   1: sign-extend iA to OUTPUT_LENGTH; 0: zero-extend
//  CLEAR_ON_READ  1   1: channel zeroed when its result is produced; 0: channel keeps accumulating
// PORTS
//  iClk        in   1               clock, rising edge
//  iRst        in   1               asynchronous, active-high reset
//  iA          in   INPUT_LENGTH    operand
//  iCh         in   CH_W            target channel
//  iValid      in   1               request valid
//  iTerminate  in   1               qualifies iValid: 0 = accumulate iA, 1 = resolve channel iCh (iA ignored)
//  oReady      out  1               request accepted on edge where iValid & oReady
//  oRes        out  OUTPUT_LENGTH   resolved sum, modulo 2^OUTPUT_LENGTH
//  oResCh      out  CH_W            channel of oRes
//  oResCount   out  16              accumulates into that channel since last clear, saturates at 16'hFFFF
//  oResValid   out  1               result valid; held until iResReady
//  iResReady   in   1               consumer accepts result on edge where oResValid & iResReady
//  oErr        out  1               one-cycle pulse: request accepted with iCh >= NUM_CHANNELS (request dropped)
// BEHAVIOUR
//  Reset (async): all channel sum/carry/count regs = 0, FSM = IDLE, oReady = 0, oResValid = 0,
//   oRes = 0, oResCh = 0, oResCount = 0, oErr = 0. oReady rises on the first edge after reset release.
//  Accumulate (3:2 compress, 1-cycle latency): for X = ext(iA), C2 = carry<<1:
//   sum' = sum^C2^X; carry' = maj(sum,C2,X); MSB carry-out dropped (modular wrap).
//   Back-to-back accumulates to the same channel at full rate. count' = sat(count+1).
//  FSM IDLE: oReady=1. Terminate accepted -> snapshot channel sum and carry<<1 into the resolver and
//   capture channel+count -> RESOLVE. If CLEAR_ON_READ=1, that channel's sum/carry/count are zeroed on the same edge.
//  RESOLVE: oReady=0. Resolver adds one ADDER_WIDTH chunk per cycle with a registered inter-chunk carry,
//   over N = OUTPUT_LENGTH/ADDER_WIDTH cycles. On the last chunk -> DONE, oRes/oResCh/oResCount loaded.
//   oResValid rises exactly N+1 edges after the terminate-accept edge.
//  DONE: oResValid=1, oReady=0, outputs stable. On iResReady -> IDLE (oResValid=0, oReady=1 the next cycle).
//  iResReady asserted while oResValid=0 has no effect. Accumulate requests are not accepted while oReady=0.
//  Invalid channel: request consumed, no state change, oErr pulses for one cycle; the FSM stays in IDLE.
//  Terminate on a never-written channel returns 0 with count 0.
//  Reset asserted mid-RESOLVE or DONE: result discarded, all state cleared immediately.
//  Width rule: SIGNED=1 results are two's complement modulo 2^OUTPUT_LENGTH; there is no overflow flag.
// STRUCTURE
//  csa_pkg: FSM state localparams (IDLE/RESOLVE/DONE), clog2 function, count width (16), adder-type constants.
//  Sub-module csa_chunk_resolver: multi-cycle chunked adder.
//   Ports: iStart, iOpA, iOpB, oRes, oDone; internal chunk counter and carry register.
//  Top level: channel register arrays, 3:2 compressor per bit, FSM, output registers.
// TESTING
//  1 Reset then ch0: accumulate 3, 5, 16'hFFFF, then terminate -> oRes=32'h00010007, oResCh=0,
//    oResCount=3, oResValid after exactly 5 edges.
//  2 Interleave ch1+=100, ch2+=7, ch1+=1, ch3 untouched. Terminate ch1 -> 101; terminate ch2 -> 7;
//    terminate ch3 -> 0 with count 0.
//  3 SIGNED=1: ch0 += 16'hFFFF (-1) five times -> oRes=32'hFFFFFFFB. OUTPUT_LENGTH=16, SIGNED=0:
//    2x 16'h8000 -> 0 (wrap).
//  4 Backpressure: hold iResReady=0 for 10 cycles -> oResValid and oRes stable, oReady=0, accumulates
//    not accepted; release -> oReady=1 next cycle.
//  5 NUM_CHANNELS=3, iCh=3 with iValid -> oErr single-cycle pulse, all channels unchanged.
//    CLEAR_ON_READ=0: terminate twice with no new data -> same value both times.
//  6 Assert iRst asynchronously mid-RESOLVE -> oResValid=0 and oReady=0 immediately;
//    after release, terminate ch0 -> 0.

Source files
------------

// File: rtl/multichannel_cs_accumulator_pkg.sv
// Shared constants and helpers for the multi-channel carry-save accumulator.
// FSM encodings are plain localparams so older code can compare against them directly.
package multichannel_cs_accumulator_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StResolve = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  localparam int unsigned CountWidth = 16;

  localparam int unsigned AdderRipple  = 0;
  localparam int unsigned AdderChunked = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multichannel_cs_accumulator_if.sv
// Request/result bus of the multi-channel carry-save accumulator.
// The master side produces operands and consumes results; the accumulator is the slave.
interface multichannel_cs_accumulator_if #(
  parameter int unsigned INPUT_LENGTH  = 16,
  parameter int unsigned OUTPUT_LENGTH = 32,
  parameter int unsigned NUM_CHANNELS  = 4
);
  localparam int unsigned CH_W = multichannel_cs_accumulator_pkg::idxWidth(NUM_CHANNELS);

  logic [INPUT_LENGTH-1:0]  iA;
  logic [CH_W-1:0]          iCh;
  logic                     iValid;
  logic                     iTerminate;
  logic                     oReady;
  logic [OUTPUT_LENGTH-1:0] oRes;
  logic [CH_W-1:0]          oResCh;
  logic [15:0]              oResCount;
  logic                     oResValid;
  logic                     iResReady;
  logic                     oErr;

  modport master (
    output iA, iCh, iValid, iTerminate, iResReady,
    input  oReady, oRes, oResCh, oResCount, oResValid, oErr
  );

  modport slave (
    input  iA, iCh, iValid, iTerminate, iResReady,
    output oReady, oRes, oResCh, oResCount, oResValid, oErr
  );

endinterface

// File: rtl/multichannel_cs_accumulator_csa_chunk_resolver.sv
// Multi-cycle carry-propagate adder: resolves iOpA + iOpB one ADDER_WIDTH chunk per cycle,
// LSB chunk first, with the inter-chunk carry held in a register.
module csa_chunk_resolver
  import multichannel_cs_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDER_WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iOpA,
  input  logic [WIDTH-1:0] iOpB,
  output logic [WIDTH-1:0] oRes,
  output logic             oDone
);

  localparam int unsigned NumChunks = WIDTH / ADDER_WIDTH;
  localparam int unsigned CntW      = idxWidth(NumChunks);
  localparam logic [CntW-1:0] LastChunk = CntW'(NumChunks - 1);

  logic [WIDTH-1:0]     opAQ, opBQ, resQ, resD;
  logic [CntW-1:0]      cntQ;
  logic                 carryQ, busyQ, doneQ;
  logic [ADDER_WIDTH:0] chunkSum;

  // Operands shift down each cycle; finished chunks enter the result from the top.
  always_comb begin
    chunkSum = {1'b0, opAQ[ADDER_WIDTH-1:0]} + {1'b0, opBQ[ADDER_WIDTH-1:0]}
             + {{ADDER_WIDTH{1'b0}}, carryQ};
    resD = resQ >> ADDER_WIDTH;
    resD[WIDTH-1 -: ADDER_WIDTH] = chunkSum[ADDER_WIDTH-1:0];
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      opAQ   <= '0;
      opBQ   <= '0;
      resQ   <= '0;
      cntQ   <= '0;
      carryQ <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else if (iStart) begin
      opAQ   <= iOpA;
      opBQ   <= iOpB;
      cntQ   <= '0;
      carryQ <= 1'b0;
      busyQ  <= 1'b1;
      doneQ  <= 1'b0;
    end else if (busyQ) begin
      opAQ   <= opAQ >> ADDER_WIDTH;
      opBQ   <= opBQ >> ADDER_WIDTH;
      resQ   <= resD;
      carryQ <= chunkSum[ADDER_WIDTH];
      cntQ   <= cntQ + CntW'(1);
      doneQ  <= (cntQ == LastChunk);
      busyQ  <= (cntQ != LastChunk);
    end else begin
      doneQ  <= 1'b0;
    end
  end

  assign oRes  = resQ;
  assign oDone = doneQ;

endmodule

// File: rtl/multichannel_cs_accumulator.sv
// NUM_CHANNELS redundant (sum, carry) accumulators fed at full rate through a 3:2 compressor,
// with one shared chunked resolver that turns a selected channel into a binary result.
module multichannel_cs_accumulator
  import multichannel_cs_accumulator_pkg::*;
#(
  parameter int unsigned INPUT_LENGTH  = 16,
  parameter int unsigned OUTPUT_LENGTH = 32,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned ADDER_WIDTH   = 8,
  parameter int unsigned SIGNED        = 0,
  parameter int unsigned CLEAR_ON_READ = 1
) (
  input logic                          iClk,
  input logic                          iRst,
  multichannel_cs_accumulator_if.slave acc
);

  localparam int unsigned CH_W = idxWidth(NUM_CHANNELS);

  logic [OUTPUT_LENGTH-1:0] sumQ   [NUM_CHANNELS];
  logic [OUTPUT_LENGTH-1:0] carryQ [NUM_CHANNELS];
  logic [CountWidth-1:0]    countQ [NUM_CHANNELS];

  logic [1:0]               stateQ, stateD;
  logic                     readyQ, validQ, errQ;
  logic [OUTPUT_LENGTH-1:0] resQ;
  logic [CH_W-1:0]          resChQ, pendChQ;
  logic [CountWidth-1:0]    resCountQ, pendCountQ;

  logic                     accept, chOk, accAcc, termAcc, signBit;
  logic [OUTPUT_LENGTH+INPUT_LENGTH-1:0] extWide;
  logic [OUTPUT_LENGTH-1:0] extA, selSum, selC2, newSum, newCarry;
  logic [CountWidth-1:0]    selCount, newCount;
  logic [OUTPUT_LENGTH-1:0] resolverRes;
  logic                     resolverDone;

  always_comb begin
    accept  = acc.iValid & readyQ;
    chOk    = ({1'b0, acc.iCh} < (CH_W + 1)'(NUM_CHANNELS));
    accAcc  = accept & ~acc.iTerminate & chOk;
    termAcc = accept & acc.iTerminate & chOk;

    // Over-wide extension then truncation also covers OUTPUT_LENGTH == INPUT_LENGTH.
    signBit = (SIGNED != 0) & acc.iA[INPUT_LENGTH-1];
    extWide = {{OUTPUT_LENGTH{signBit}}, acc.iA};
    extA    = extWide[OUTPUT_LENGTH-1:0];

    selSum   = sumQ[acc.iCh];
    selC2    = carryQ[acc.iCh] << 1;
    selCount = countQ[acc.iCh];
    newSum   = selSum ^ selC2 ^ extA;
    newCarry = (selSum & selC2) | (selSum & extA) | (selC2 & extA);
    newCount = (selCount == '1) ? selCount : selCount + CountWidth'(1);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        sumQ[c]   <= '0;
        carryQ[c] <= '0;
        countQ[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        if (acc.iCh == CH_W'(c)) begin
          if (accAcc) begin
            sumQ[c]   <= newSum;
            carryQ[c] <= newCarry;
            countQ[c] <= newCount;
          end else if (termAcc && (CLEAR_ON_READ != 0)) begin
            sumQ[c]   <= '0;
            carryQ[c] <= '0;
            countQ[c] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:    if (termAcc) stateD = StResolve;
      StResolve: if (resolverDone) stateD = StDone;
      StDone:    if (acc.iResReady) stateD = StIdle;
      default:   stateD = StIdle;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ     <= StIdle;
      readyQ     <= 1'b0;
      validQ     <= 1'b0;
      errQ       <= 1'b0;
      resQ       <= '0;
      resChQ     <= '0;
      resCountQ  <= '0;
      pendChQ    <= '0;
      pendCountQ <= '0;
    end else begin
      stateQ <= stateD;
      readyQ <= (stateD == StIdle);
      validQ <= (stateD == StDone);
      errQ   <= accept & ~chOk;
      if (termAcc) begin
        pendChQ    <= acc.iCh;
        pendCountQ <= selCount;
      end
      if (stateQ == StResolve && resolverDone) begin
        resQ      <= resolverRes;
        resChQ    <= pendChQ;
        resCountQ <= pendCountQ;
      end
    end
  end

  csa_chunk_resolver #(
    .WIDTH       (OUTPUT_LENGTH),
    .ADDER_WIDTH (ADDER_WIDTH)
  ) uResolver (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (termAcc),
    .iOpA   (selSum),
    .iOpB   (selC2),
    .oRes   (resolverRes),
    .oDone  (resolverDone)
  );

  assign acc.oReady    = readyQ;
  assign acc.oRes      = resQ;
  assign acc.oResCh    = resChQ;
  assign acc.oResCount = resCountQ;
  assign acc.oResValid = validQ;
  assign acc.oErr      = errQ;

endmodule

// File: tb/tb_multichannel_cs_accumulator.sv
// Directed bench: four accumulator configurations share one stimulus bus selected by sel.
module tb_multichannel_cs_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel;

  logic [15:0] tA;
  logic [1:0]  tCh;
  logic        tValid, tTerm, tResReady;

  logic        obsReady, obsValid, obsErr;
  logic [31:0] obsRes;
  logic [1:0]  obsResCh;
  logic [15:0] obsCount;

  multichannel_cs_accumulator_if #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .NUM_CHANNELS(4)) ifA ();
  multichannel_cs_accumulator_if #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .NUM_CHANNELS(4)) ifS ();
  multichannel_cs_accumulator_if #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(16), .NUM_CHANNELS(4)) ifW ();
  multichannel_cs_accumulator_if #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .NUM_CHANNELS(3)) ifE ();

  multichannel_cs_accumulator #(
    .INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .NUM_CHANNELS(4), .ADDER_WIDTH(8), .SIGNED(0),
    .CLEAR_ON_READ(1)
  ) dutA (.iClk(clk), .iRst(rst), .acc(ifA));

  multichannel_cs_accumulator #(
    .INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .NUM_CHANNELS(4), .ADDER_WIDTH(8), .SIGNED(1),
    .CLEAR_ON_READ(1)
  ) dutS (.iClk(clk), .iRst(rst), .acc(ifS));

  multichannel_cs_accumulator #(
    .INPUT_LENGTH(16), .OUTPUT_LENGTH(16), .NUM_CHANNELS(4), .ADDER_WIDTH(8), .SIGNED(0),
    .CLEAR_ON_READ(1)
  ) dutW (.iClk(clk), .iRst(rst), .acc(ifW));

  multichannel_cs_accumulator #(
    .INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .NUM_CHANNELS(3), .ADDER_WIDTH(8), .SIGNED(0),
    .CLEAR_ON_READ(0)
  ) dutE (.iClk(clk), .iRst(rst), .acc(ifE));

  assign ifA.iA = tA;  assign ifA.iCh = tCh;  assign ifA.iTerminate = tTerm;
  assign ifS.iA = tA;  assign ifS.iCh = tCh;  assign ifS.iTerminate = tTerm;
  assign ifW.iA = tA;  assign ifW.iCh = tCh;  assign ifW.iTerminate = tTerm;
  assign ifE.iA = tA;  assign ifE.iCh = tCh;  assign ifE.iTerminate = tTerm;
  assign ifA.iValid = tValid && (sel == 0);  assign ifA.iResReady = tResReady && (sel == 0);
  assign ifS.iValid = tValid && (sel == 1);  assign ifS.iResReady = tResReady && (sel == 1);
  assign ifW.iValid = tValid && (sel == 2);  assign ifW.iResReady = tResReady && (sel == 2);
  assign ifE.iValid = tValid && (sel == 3);  assign ifE.iResReady = tResReady && (sel == 3);

  always_comb begin
    obsReady = ifA.oReady;
    obsValid = ifA.oResValid;
    obsErr   = ifA.oErr;
    obsRes   = ifA.oRes;
    obsResCh = ifA.oResCh;
    obsCount = ifA.oResCount;
    case (sel)
      1: begin
        obsReady = ifS.oReady;  obsValid = ifS.oResValid;  obsErr = ifS.oErr;
        obsRes = ifS.oRes;  obsResCh = ifS.oResCh;  obsCount = ifS.oResCount;
      end
      2: begin
        obsReady = ifW.oReady;  obsValid = ifW.oResValid;  obsErr = ifW.oErr;
        obsRes = {16'h0000, ifW.oRes};  obsResCh = ifW.oResCh;  obsCount = ifW.oResCount;
      end
      3: begin
        obsReady = ifE.oReady;  obsValid = ifE.oResValid;  obsErr = ifE.oErr;
        obsRes = ifE.oRes;  obsResCh = ifE.oResCh;  obsCount = ifE.oResCount;
      end
      default: ;
    endcase
  end

  // Leaves the request asserted; the next driving task replaces or clears it.
  task automatic accumulate(input logic [1:0] ch, input logic [15:0] a);
    @(negedge clk);
    tValid = 1'b1;  tTerm = 1'b0;  tCh = ch;  tA = a;
  endtask

  task automatic resolve(input logic [1:0] ch, output logic [31:0] res, output logic [1:0] resCh,
                         output logic [15:0] cnt, output int edges);
    @(negedge clk);
    tValid = 1'b1;  tTerm = 1'b1;  tCh = ch;  tA = 16'hDEAD;
    @(negedge clk);
    tValid = 1'b0;  tTerm = 1'b0;
    edges = 0;
    while (!obsValid && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checks++;
    if (obsValid !== 1'b1) begin
      errors++;
      $display("FAIL resolve_timeout ch%0d: oResValid=%b after %0d edges, required 1",
               ch, obsValid, edges);
    end
    res = obsRes;  resCh = obsResCh;  cnt = obsCount;
  endtask

  task automatic ack();
    @(negedge clk);
    tResReady = 1'b1;
    @(negedge clk);
    tResReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks++;
      if ({obsReady, obsValid, obsErr, obsResCh, obsCount, obsRes} !== 53'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got rdy=%b vld=%b err=%b ch=%0d cnt=%0d res=%h, all 0",
                 s, obsReady, obsValid, obsErr, obsResCh, obsCount, obsRes);
      end
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obsReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b, expected 0", obsReady);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obsReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b, expected 1", obsReady);
    end
  endtask

  task automatic test_basic();
    logic [31:0] res;  logic [1:0] ch;  logic [15:0] cnt;  int edges;
    sel = 0;
    accumulate(2'd0, 16'd3);
    accumulate(2'd0, 16'd5);
    accumulate(2'd0, 16'hFFFF);
    resolve(2'd0, res, ch, cnt, edges);
    checks++;
    if (res !== 32'h0001_0007) begin
      errors++;  $display("FAIL basic_res: got %h, expected 00010007", res);
    end
    checks++;
    if (ch !== 2'd0 || cnt !== 16'd3) begin
      errors++;  $display("FAIL basic_ch_count: got ch=%0d cnt=%0d, expected ch=0 cnt=3", ch, cnt);
    end
    checks++;
    if (edges != 5) begin
      errors++;  $display("FAIL basic_latency: got %0d edges, expected 5", edges);
    end
    ack();
    checks++;
    if (obsReady !== 1'b1 || obsValid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: got rdy=%b vld=%b, expected rdy=1 vld=0", obsReady, obsValid);
    end
  endtask

  task automatic test_interleave();
    logic [31:0] res;  logic [1:0] ch;  logic [15:0] cnt;  int edges;
    logic [49:0] expv [4];
    logic [1:0]  chan [4];
    expv[0] = {32'd101, 2'd1, 16'd2};  chan[0] = 2'd1;
    expv[1] = {32'd7,   2'd2, 16'd1};  chan[1] = 2'd2;
    expv[2] = {32'd0,   2'd3, 16'd0};  chan[2] = 2'd3;
    expv[3] = {32'd0,   2'd0, 16'd0};  chan[3] = 2'd0;
    sel = 0;
    accumulate(2'd1, 16'd100);
    accumulate(2'd2, 16'd7);
    accumulate(2'd1, 16'd1);
    for (int i = 0; i < 4; i++) begin
      resolve(chan[i], res, ch, cnt, edges);
      checks++;
      if ({res, ch, cnt} !== expv[i]) begin
        errors++;
        $display("FAIL interleave_ch%0d: got res=%h ch=%0d cnt=%0d, expected res=%h ch=%0d cnt=%0d",
                 chan[i], res, ch, cnt, expv[i][49:18], expv[i][17:16], expv[i][15:0]);
      end
      ack();
    end
  endtask

  task automatic test_signed_and_wrap();
    logic [31:0] res;  logic [1:0] ch;  logic [15:0] cnt;  int edges;
    sel = 1;
    for (int i = 0; i < 5; i++) accumulate(2'd0, 16'hFFFF);
    resolve(2'd0, res, ch, cnt, edges);
    checks++;
    if (res !== 32'hFFFF_FFFB || cnt !== 16'd5) begin
      errors++;  $display("FAIL signed_neg: got res=%h cnt=%0d, expected FFFFFFFB cnt=5", res, cnt);
    end
    ack();
    accumulate(2'd1, 16'd5);
    accumulate(2'd1, 16'hFFFE);
    resolve(2'd1, res, ch, cnt, edges);
    checks++;
    if (res !== 32'd3 || ch !== 2'd1) begin
      errors++;  $display("FAIL signed_mixed: got res=%h ch=%0d, expected 00000003 ch=1", res, ch);
    end
    ack();
    sel = 2;
    accumulate(2'd0, 16'h8000);
    accumulate(2'd0, 16'h8000);
    resolve(2'd0, res, ch, cnt, edges);
    checks++;
    if (res !== 32'd0 || cnt !== 16'd2) begin
      errors++;  $display("FAIL wrap16_zero: got res=%h cnt=%0d, expected 0 cnt=2", res, cnt);
    end
    checks++;
    if (edges != 3) begin
      errors++;  $display("FAIL wrap16_latency: got %0d edges, expected 3", edges);
    end
    ack();
    accumulate(2'd1, 16'hFFFF);
    accumulate(2'd1, 16'd2);
    resolve(2'd1, res, ch, cnt, edges);
    checks++;
    if (res !== 32'd1) begin
      errors++;  $display("FAIL wrap16_one: got res=%h, expected 00000001", res);
    end
    ack();
    sel = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] res;  logic [1:0] ch;  logic [15:0] cnt;  int edges;
    sel = 0;
    accumulate(2'd0, 16'd42);
    resolve(2'd0, res, ch, cnt, edges);
    checks++;
    if (res !== 32'd42) begin
      errors++;  $display("FAIL bp_first: got res=%h, expected 0000002A", res);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tValid = 1'b1;  tTerm = 1'b0;  tCh = 2'd0;  tA = 16'd1;
      checks++;
      if (obsValid !== 1'b1 || obsRes !== 32'd42 || obsReady !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle%0d: got vld=%b res=%h rdy=%b, expected vld=1 res=2A rdy=0",
                 i, obsValid, obsRes, obsReady);
      end
    end
    @(negedge clk);
    tValid = 1'b0;
    ack();
    checks++;
    if (obsReady !== 1'b1 || obsValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b, expected rdy=1 vld=0", obsReady, obsValid);
    end
    resolve(2'd0, res, ch, cnt, edges);
    checks++;
    if (res !== 32'd0 || cnt !== 16'd0) begin
      errors++;  $display("FAIL bp_no_accept: got res=%h cnt=%0d, expected 0 cnt=0", res, cnt);
    end
    ack();
  endtask

  task automatic test_invalid_channel();
    logic [31:0] res;  logic [1:0] ch;  logic [15:0] cnt;  int edges;
    logic [31:0] expRes [4];
    logic [1:0]  chan [4];
    expRes[0] = 32'd10;  chan[0] = 2'd0;
    expRes[1] = 32'd10;  chan[1] = 2'd0;
    expRes[2] = 32'd20;  chan[2] = 2'd1;
    expRes[3] = 32'd30;  chan[3] = 2'd2;
    sel = 3;
    accumulate(2'd0, 16'd10);
    accumulate(2'd1, 16'd20);
    accumulate(2'd2, 16'd30);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      tValid = 1'b1;  tTerm = (t == 1);  tCh = 2'd3;  tA = 16'd99;
      @(negedge clk);
      tValid = 1'b0;  tTerm = 1'b0;
      checks++;
      if (obsErr !== 1'b1 || obsReady !== 1'b1 || obsValid !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse term=%0d: got err=%b rdy=%b vld=%b, expected err=1 rdy=1 vld=0",
                 t, obsErr, obsReady, obsValid);
      end
      @(negedge clk);
      checks++;
      if (obsErr !== 1'b0 || obsValid !== 1'b0) begin
        errors++;
        $display("FAIL err_single term=%0d: got err=%b vld=%b, expected err=0 vld=0",
                 t, obsErr, obsValid);
      end
    end
    for (int i = 0; i < 4; i++) begin
      resolve(chan[i], res, ch, cnt, edges);
      checks++;
      if (res !== expRes[i] || ch !== chan[i] || cnt !== 16'd1) begin
        errors++;
        $display("FAIL keep_read%0d: got res=%h ch=%0d cnt=%0d, expected res=%h ch=%0d cnt=1",
                 i, res, ch, cnt, expRes[i], chan[i]);
      end
      ack();
    end
    sel = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] res;  logic [1:0] ch;  logic [15:0] cnt;  int edges;
    sel = 0;
    accumulate(2'd0, 16'd77);
    resolve(2'd0, res, ch, cnt, edges);
    checks++;
    if (res !== 32'd77) begin
      errors++;  $display("FAIL rst_pre: got res=%h, expected 0000004D", res);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obsValid !== 1'b0 || obsReady !== 1'b0 || obsRes !== 32'd0) begin
      errors++;
      $display("FAIL rst_in_done: got vld=%b rdy=%b res=%h, expected vld=0 rdy=0 res=0",
               obsValid, obsReady, obsRes);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    accumulate(2'd1, 16'd9);
    accumulate(2'd0, 16'd5);
    @(negedge clk);
    tTerm = 1'b1;  tCh = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (obsValid !== 1'b0 || obsReady !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_resolve: got vld=%b rdy=%b, expected vld=0 rdy=0", obsValid, obsReady);
    end
    @(negedge clk);
    rst = 1'b0;  tValid = 1'b0;  tTerm = 1'b0;
    @(posedge clk);
    resolve(2'd0, res, ch, cnt, edges);
    checks++;
    if (res !== 32'd0 || cnt !== 16'd0) begin
      errors++;  $display("FAIL rst_ch0: got res=%h cnt=%0d, expected 0 cnt=0", res, cnt);
    end
    ack();
    resolve(2'd1, res, ch, cnt, edges);
    checks++;
    if (res !== 32'd0 || cnt !== 16'd0) begin
      errors++;  $display("FAIL rst_ch1: got res=%h cnt=%0d, expected 0 cnt=0", res, cnt);
    end
    ack();
  endtask

  initial begin
    sel = 0;
    tA = '0;  tCh = '0;  tValid = 1'b0;  tTerm = 1'b0;  tResReady = 1'b0;
    test_reset();
    test_basic();
    test_interleave();
    test_signed_and_wrap();
    test_backpressure();
    test_invalid_channel();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
